// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types and widths for the integer pipeline.
//   XLEN       : datapath width
//   REG_AW     : register address width
//   alu_op_e   : 3-bit ALU opcode encoding
//   fwd_sel_e  : operand source selected by the forwarding network
//   fwd_select : priority selection of a forwarding source for one operand
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLL = 3'd5,
    SRL = 3'd6,
    SLT = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // EX/MEM is the younger producer, so it wins over MEM/WB. x0 is hardwired
  // to zero and is therefore never a forwarding target.
  function automatic fwd_sel_e fwd_select(
    input logic              exm_wr_en,
    input logic [REG_AW-1:0] exm_rd,
    input logic              wb_wr_en,
    input logic [REG_AW-1:0] wb_rd,
    input logic [REG_AW-1:0] src
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (exm_wr_en && (exm_rd != '0) && (exm_rd == src)) begin
      sel = FWD_EXM;
    end else if (wb_wr_en && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Resolves one source operand against the EX/MEM and MEM/WB write ports.
// Ports:
//   src_addr   : source register address of the held instruction
//   rf_val     : register file value captured with the instruction
//   exm_*      : EX/MEM write port (enable, destination, data)
//   wb_*       : MEM/WB write port (enable, destination, data)
//   fwd_val    : forwarded operand value
// ---------------------------------------------------------------------------
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [XLEN-1:0]   rf_val,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   fwd_val
);

  fwd_sel_e sel;

  // Address compare first, then a plain three-way data select.
  always_comb begin
    sel = fwd_select(exm_wr_en, exm_rd, wb_wr_en, wb_rd, src_addr);
    fwd_val = rf_val;
    case (sel)
      FWD_EXM: fwd_val = exm_data;
      FWD_WB:  fwd_val = wb_data;
      default: fwd_val = rf_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding feeding the execute ALU.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : decode handshake
//   in_rs1/rs2_addr/val : source addresses and register file read data
//   in_imm, in_use_imm  : immediate and operand-b select
//   in_alu_op           : ALU opcode
//   in_rd, in_reg_write : destination info
//   flush               : kill held instruction (branch redirect)
//   exm_*, wb_*         : EX/MEM and MEM/WB forwarding sources
//   out_valid/out_ready : execute handshake
//   alu_a, alu_b        : forwarded ALU operands
//   alu_opcode          : ALU opcode
//   store_data          : forwarded rs2
//   out_rd              : destination register
//   out_reg_write       : destination write enable, qualified by out_valid
// Build option:
//   ID_EX_STAT_EN       : adds stall_cnt and flush_cnt 32-bit counters
// ---------------------------------------------------------------------------
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_alu_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [2:0]        alu_opcode,
  output logic [XLEN-1:0]   store_data,
  output logic [REG_AW-1:0] out_rd,
`ifdef ID_EX_STAT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              out_reg_write
);

  logic              valid_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [XLEN-1:0]   rs1_val_q;
  logic [XLEN-1:0]   rs2_val_q;
  logic [XLEN-1:0]   imm_q;
  logic              use_imm_q;
  alu_op_e           alu_op_q;
  logic [REG_AW-1:0] rd_q;
  logic              reg_write_q;

  logic              accept;
  logic              stalled;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign stalled  = valid_q && !out_ready;

  // Valid bit: flush dominates, an accepted beat refills the stage, and a
  // drained beat with nothing behind it empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Field registers. While stalled, a retiring MEM/WB write to one of our
  // sources is folded into the captured value; otherwise the producer would
  // leave the forwarding window and the stage would present stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_op_q    <= ADD;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (accept) begin
      rs1_q       <= in_rs1_addr;
      rs2_q       <= in_rs2_addr;
      rs1_val_q   <= in_rs1_val;
      rs2_val_q   <= in_rs2_val;
      imm_q       <= in_imm;
      use_imm_q   <= in_use_imm;
      alu_op_q    <= alu_op_e'(in_alu_op);
      rd_q        <= in_rd;
      reg_write_q <= in_reg_write;
    end else if (stalled) begin
      if (wb_wr_en && (wb_rd != '0) && (wb_rd == rs1_q)) begin
        rs1_val_q <= wb_data;
      end
      if (wb_wr_en && (wb_rd != '0) && (wb_rd == rs2_q)) begin
        rs2_val_q <= wb_data;
      end
    end
  end

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .src_addr  (rs1_q),
    .rf_val    (rs1_val_q),
    .exm_wr_en (exm_wr_en),
    .exm_rd    (exm_rd),
    .exm_data  (exm_data),
    .wb_wr_en  (wb_wr_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .fwd_val   (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .src_addr  (rs2_q),
    .rf_val    (rs2_val_q),
    .exm_wr_en (exm_wr_en),
    .exm_rd    (exm_rd),
    .exm_data  (exm_data),
    .wb_wr_en  (wb_wr_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .fwd_val   (fwd_rs2)
  );

  assign out_valid     = valid_q;
  assign alu_a         = fwd_rs1;
  assign alu_b         = use_imm_q ? imm_q : fwd_rs2;
  assign store_data    = fwd_rs2;
  assign alu_opcode    = alu_op_q;
  assign out_rd        = rd_q;
  assign out_reg_write = reg_write_q & valid_q;

`ifdef ID_EX_STAT_EN
  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stalled) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && valid_q) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with operand forwarding. It sits directly upstream of the execute-stage ALU.
- Captures decoded instruction fields under a valid/ready handshake and resolves RAW hazards from the EX/MEM and MEM/WB stages.
- Drives the ALU operands (a, b) and the 3-bit ALU opcode, and passes destination info to EX/MEM.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode beat valid
- in_ready  out  1  stage can accept a beat
- in_rs1_addr, in_rs2_addr  in  REG_AW  source register addresses
- in_rs1_val, in_rs2_val  in  XLEN  register file read data
- in_imm  in  XLEN  sign-extended immediate
- in_use_imm  in  1  1 = operand b is imm
- in_alu_op  in  3  ALU opcode (000 ADD … 111 SLT)
- in_rd  in  REG_AW  destination register
- in_reg_write  in  1  instruction writes rd
- flush  in  1  kill the held instruction (branch redirect)
- exm_wr_en, exm_rd, exm_data  in  1/REG_AW/XLEN  EX/MEM forward source
- wb_wr_en, wb_rd, wb_data  in  1/REG_AW/XLEN  MEM/WB forward source
- out_valid  out  1  ALU operands valid
- out_ready  in  1  EX/MEM accepts
- alu_a, alu_b  out  XLEN  ALU operands
- alu_opcode  out  3  to ALU opcode
- store_data  out  XLEN  forwarded rs2
- out_rd  out  REG_AW  destination register
- out_reg_write  out  1  equals reg_write_q & out_valid

Behaviour:
- Reset (async, rst_n=0): valid_q=0; all field registers 0. Outputs: out_valid=0, alu_opcode=000, out_rd=0, out_reg_write=0.
- in_ready = !valid_q || out_ready (combinational). A beat is accepted when in_valid && in_ready.
- Accept: capture all in_* fields and set valid_q=1 next edge. Latency is one cycle from accept to out_valid.
- out_ready && valid_q && !in_valid: valid_q=0 next edge.
- Back-to-back throughput is 1 beat/cycle.
- Flush has highest priority: valid_q=0 next edge regardless of accept. A beat accepted in the same cycle is discarded.
- Forwarding is combinational from the registered fields. For rs1 (rs2 identical):
  - if exm_wr_en && exm_rd!=0 && exm_rd==rs1_q, select exm_data;
  - else if wb_wr_en && wb_rd!=0 && wb_rd==rs1_q, select wb_data;
  - else select rs1_val_q.
- EX/MEM wins over WB. rd=0 never forwards.
- alu_a = fwd_rs1. alu_b = use_imm_q ? imm_q : fwd_rs2. store_data = fwd_rs2.
- Held-beat refresh: while valid_q && !out_ready, a WB write matching rs1_q/rs2_q (rd!=0) overwrites rs1_val_q/rs2_val_q with wb_data. This prevents stale operands after the producer retires during a stall.
- Outputs are defined only while out_valid=1; downstream ignores them otherwise.
- Reset mid-stall drops the held beat; no residual valid.

Optional Feature:
- ID_EX_STAT_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset 0 and wrapping at 2^32.
  - stall_cnt increments when valid_q && !out_ready.
  - flush_cnt increments when flush && valid_q.
- Undefined: no counters and no such ports.

Decomposition:
- riscv_pkg:
  - XLEN, REG_AW
  - alu_op_e enum: ADD=0, SUB, AND, OR, XOR, SLL, SRL, SLT=7
  - fwd_sel_e enum: FWD_RF, FWD_EXM, FWD_WB
- Sub-module fwd_mux: address compare plus 3-way select, instantiated for rs1 and rs2.

Test Plan:
- Reset with rst_n=0 mid-beat -> out_valid=0, alu_opcode=000, out_reg_write=0 immediately (asynchronous).
- Accept rs1_val=5, rs2_val=7, op=ADD, use_imm=0 -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_opcode=000.
- rs1_q=3 with exm_rd=3/exm_data=0xAA and wb_rd=3/wb_data=0xBB -> alu_a=0xAA. Then exm_wr_en=0 -> alu_a=0xBB. rd=0 match -> no forward.
- use_imm=1, imm=0xFFFFFFFC, rs2 forwarded 0x11 -> alu_b=0xFFFFFFFC, store_data=0x11.
- out_ready=0 for 3 cycles, WB writes rs2 (rd=4, 0x1234) then deasserts -> in_ready=0 throughout; after release alu_b/store_data=0x1234.
- flush while held, with in_valid=1 same cycle -> next cycle out_valid=0, new beat not presented.
